// File: rtl/processor_v2.sv
// Multi-cycle accumulator-style processor: FETCH / EXEC / MEM / HALT over a single
// word-addressed memory port with a ready handshake. All bus outputs are registered.
module processor_v2 #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clock,
  input  logic              resetn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] bus,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_t;

  localparam logic [2:0] OpMv  = 3'b000;
  localparam logic [2:0] OpMvt = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;
  localparam logic [2:0] OpLd  = 3'b100;
  localparam logic [2:0] OpSt  = 3'b101;
  localparam logic [2:0] OpAnd = 3'b110;
  localparam logic [2:0] OpBr  = 3'b111;

  state_t            state;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [8];
  logic              flag_z, flag_n, flag_c;

  logic [2:0]        opc;
  logic [2:0]        rx;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W-1:0] rx_val;
  logic [DATA_W:0]   add_full;
  logic [DATA_W:0]   sub_full;
  logic              wr_en;
  logic [DATA_W-1:0] wr_val;
  logic              set_flags;
  logic              res_c;
  logic              take;
  logic              is_halt;
  logic [ADDR_W-1:0] pc_after;
  logic [ADDR_W-1:0] op_addr;

  always_comb begin
    opc       = ir[15:13];
    rx        = ir[11:9];
    opnd      = ir[12] ? DATA_W'(ir[8:0]) : regs[ir[2:0]];
    rx_val    = regs[rx];
    op_addr   = opnd[ADDR_W-1:0];
    add_full  = {1'b0, rx_val} + {1'b0, opnd};
    // Carry of rX + ~op + 1: set means no borrow.
    sub_full  = {1'b0, rx_val} + {1'b0, ~opnd} + (DATA_W+1)'(1);
    wr_en     = 1'b0;
    wr_val    = '0;
    set_flags = 1'b0;
    res_c     = 1'b0;
    case (opc)
      OpMv: begin
        wr_en  = 1'b1;
        wr_val = opnd;
      end
      OpMvt: begin
        wr_en  = 1'b1;
        wr_val = DATA_W'(ir[7:0]) << (DATA_W - 8);
      end
      OpAdd: begin
        wr_en     = 1'b1;
        set_flags = 1'b1;
        wr_val    = add_full[DATA_W-1:0];
        res_c     = add_full[DATA_W];
      end
      OpSub: begin
        wr_en     = 1'b1;
        set_flags = 1'b1;
        wr_val    = sub_full[DATA_W-1:0];
        res_c     = sub_full[DATA_W];
      end
      OpAnd: begin
        wr_en     = 1'b1;
        set_flags = 1'b1;
        wr_val    = rx_val & opnd;
      end
      default: ;
    endcase

    take = 1'b0;
    case (rx)
      3'b000:  take = 1'b1;
      3'b001:  take = flag_z;
      3'b010:  take = !flag_z;
      3'b011:  take = !flag_c;
      3'b100:  take = flag_c;
      3'b101:  take = !flag_n;
      3'b110:  take = flag_n;
      default: take = 1'b0;
    endcase
    is_halt  = (opc == OpBr) && (rx == 3'b111);
    // pc already points past the branch, so the offset is relative to pc_next.
    pc_after = ((opc == OpBr) && take) ? pc + ADDR_W'($signed(ir[8:0])) : pc;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= StFetch;
      pc        <= '0;
      ir        <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      bus       <= '0;
      halted    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        StFetch: begin
          // Right after reset no fetch is outstanding yet, so issue one.
          if (!mem_rd) begin
            mem_rd   <= 1'b1;
            mem_addr <= pc;
          end else if (mem_ready) begin
            ir     <= mem_rdata[15:0];
            pc     <= pc + ADDR_W'(1);
            mem_rd <= 1'b0;
            state  <= StExec;
          end
        end
        StExec: begin
          if (opc == OpLd) begin
            mem_rd   <= 1'b1;
            mem_addr <= op_addr;
            state    <= StMem;
          end else if (opc == OpSt) begin
            mem_wr    <= 1'b1;
            mem_addr  <= op_addr;
            mem_wdata <= rx_val;
            state     <= StMem;
          end else if (is_halt) begin
            halted <= 1'b1;
            state  <= StHalt;
          end else begin
            if (wr_en) begin
              regs[rx] <= wr_val;
              bus      <= wr_val;
            end
            if (set_flags) begin
              flag_z <= (wr_val == '0);
              flag_n <= wr_val[DATA_W-1];
              flag_c <= res_c;
            end
            pc       <= pc_after;
            mem_rd   <= 1'b1;
            mem_addr <= pc_after;
            state    <= StFetch;
          end
        end
        StMem: begin
          if (mem_ready) begin
            if (mem_rd) begin
              regs[rx] <= mem_rdata;
              bus      <= mem_rdata;
            end
            mem_wr   <= 1'b0;
            mem_rd   <= 1'b1;
            mem_addr <= pc;
            state    <= StFetch;
          end
        end
        default: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/processor_v2.md
PROCESSOR_V2 -- requirements
Module: processor_v2

Interface
Parameters (one per line: name, default, meaning)
REQ-001 The block SHALL have parameter DATA_W, default 16, register/ALU/data-bus width; legal values are 16 to 64.
REQ-002 The block SHALL have parameter ADDR_W, default 6, memory word-address width; legal values are 4 to 16.

Ports (name, direction, width, meaning)
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1, reset that is synchronous and active-low.
REQ-005 The block SHALL have port mem_addr, output, ADDR_W, memory word address.
REQ-006 The block SHALL have port mem_rd, output, 1, read request.
REQ-007 The block SHALL have port mem_wr, output, 1, write request.
REQ-008 The block SHALL have port mem_wdata, output, DATA_W, write data.
REQ-009 The block SHALL have port mem_rdata, input, DATA_W, read data, valid when mem_ready=1.
REQ-010 The block SHALL have port mem_ready, input, 1, completes the pending request at that edge.
REQ-011 The block SHALL have port bus, output, DATA_W, last register-file write value.
REQ-012 The block SHALL have port pc, output, ADDR_W, current program counter.
REQ-013 The block SHALL have port halted, output, 1, high in the HALT state.

Function
REQ-014 The block SHALL contain eight DATA_W registers r0-r7, flags Z/N/C, an ADDR_W pc and a 16-bit IR.
REQ-015 Instruction encoding SHALL use IR = mem_rdata[15:0]: op[15:13], I[12], rX[11:9], and operand field [8:0]; operand = I ? zero-extended imm9 : r[[2:0]].
REQ-016 Opcodes SHALL be: 000 mv rX<=op; 001 mvt rX<=imm8[7:0]<<(DATA_W-8); 010 add; 011 sub; 100 ld rX<=mem[op]; 101 st mem[op]<=rX; 110 and; 111 branch.
REQ-017 Memory addresses from an operand SHALL use operand[ADDR_W-1:0].
REQ-018 add/sub/and SHALL write rX and update the flags: Z = result==0; N = result MSB; C = carry-out of add, carry-out of rX+~op+1 for sub (1 = no borrow), and 0 for and. Other opcodes SHALL leave the flags unchanged.
REQ-019 branch SHALL decode cond=[11:9]: 000 always, 001 Z, 010 !Z, 011 !C, 100 C, 101 !N, 110 N, 111 halt.
REQ-020 A taken branch SHALL set pc <= pc_next + sext(imm9), truncated to ADDR_W; a not-taken branch SHALL leave pc_next.
REQ-021 The FSM SHALL have states FETCH, EXEC, MEM, HALT.
REQ-022 FETCH SHALL drive mem_rd=1 and mem_addr=pc; on mem_ready it SHALL latch IR, set pc<=pc+1 (mod 2^ADDR_W), and go to EXEC; otherwise it SHALL hold.
REQ-023 EXEC SHALL complete mv/mvt/add/sub/and/branch in one cycle and return to FETCH; ld/st SHALL go to MEM; cond 111 SHALL go to HALT.
REQ-024 MEM SHALL drive mem_rd (ld) or mem_wr with mem_wdata=rX (st) and mem_addr=op address; on mem_ready, ld SHALL write rX<=mem_rdata, then the FSM SHALL go to FETCH.
REQ-025 mem_addr, mem_wdata and the request SHALL be held stable until the edge where mem_ready=1.
REQ-026 mem_rd and mem_wr SHALL never be high together.
REQ-027 mem_ready while no request is asserted SHALL be ignored.
REQ-028 Latency with mem_ready tied high SHALL be 2 cycles for non-memory instructions and 3 cycles for ld/st.
REQ-029 bus SHALL update in the cycle following each register write, to the written value, and SHALL hold otherwise.
REQ-030 A write to rX whose source is rX (e.g. add r0,r0) SHALL use pre-write values.
REQ-031 HALT SHALL assert halted=1 and drive no requests; the FSM SHALL remain in HALT until reset.

Reset
REQ-032 When resetn=0 at a rising edge, the block SHALL set pc=0, r0-r7=0, Z=N=C=0, IR=0, bus=0, halted=0, mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0, and state=FETCH.
REQ-033 Reset SHALL override any in-flight request; mem_rd/mem_wr SHALL deassert the cycle after the reset edge, with no register write.
REQ-034 Fetch SHALL begin in the first cycle with resetn=1.

Verification
REQ-035 With mem_ready=1: mv r0,#5; mv r1,#3; add r0,r1 -> bus=8, Z=0, N=0, C=0, each instruction taking 2 cycles.
REQ-036 With r0=7: sub r0,r0 -> r0=0, Z=1, C=1; then beq +2 -> pc skips two words (from 3 to 5).
REQ-037 With mem_ready low for 3 cycles per request: st r2(=0x00AB),#10 -> mem_wr/addr=10/wdata held 4 cycles; ld r3,#10 -> r3=0x00AB, bus=0x00AB.
REQ-038 With DATA_W=16: 0xFFFF+1 -> result 0, Z=1, C=1. With DATA_W=32: the same operands -> 0x00010000, Z=0, C=0; mvt r1,#0x12 -> 0x12000000.
REQ-039 A branch with cond 111 -> halted=1 and no further mem_rd; with pc=63, ADDR_W=6, executing any non-branch -> pc wraps to 0.
REQ-040 resetn=0 for one edge during FETCH with mem_ready=0 -> mem_rd=0 the next cycle, pc=0, then fetch of address 0 resumes.
